ref_win_fetch: RTL and testbench

//  Parametrised reference-window fetcher for the affine MC path; successor to the fixed 4x4/9-row fetcher.

---
 rtl/ref_win_fetch.sv | 143 ++++++++++++++
 tb/tb_ref_win_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ref_win_fetch.sv
// Reference-window fetcher: word RAM with a load port, two-port row reads, and
// per-column pixel selectors that assemble a WIN x WIN window plus sideband.

module ref_win_pix_sel #(
  parameter int PIX_W    = 8,
  parameter int LINE_PIX = 16,
  parameter int COL      = 0
) (
  input  logic [2*LINE_PIX-1:0][PIX_W-1:0] pair,
  input  logic [$clog2(LINE_PIX)-1:0]      pos,
  output logic [PIX_W-1:0]                 pix
);
  localparam int IW = $clog2(2*LINE_PIX);

  logic [IW-1:0] idx;

  assign idx = IW'(pos) + IW'(COL);
  assign pix = pair[idx];
endmodule

module ref_win_fetch #(
  parameter  int PIX_W     = 8,
  parameter  int LINE_PIX  = 16,
  parameter  int RAM_DEPTH = 512,
  parameter  int ROW_WORDS = 8,
  parameter  int BLK       = 4,
  parameter  int TAPS      = 6,
  parameter  int SB_W      = 192,
  localparam int AW        = $clog2(RAM_DEPTH),
  localparam int PW        = $clog2(LINE_PIX),
  localparam int LINE_W    = LINE_PIX*PIX_W,
  localparam int WIN       = BLK+TAPS-1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [LINE_W-1:0]        wr_data,
  output logic                     wr_drop,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  input  logic [PW-1:0]            req_pos,
  input  logic [SB_W-1:0]          req_sb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIN*WIN*PIX_W-1:0] out_win,
  output logic [SB_W-1:0]          out_sb,
  output logic                     busy
);
  localparam int CW = $clog2(WIN+1);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [PW-1:0]   pos;
    logic [SB_W-1:0] sb;
  } req_t;

  state_t state, state_nx;
  req_t   req_q;
  logic   accept;

  logic [LINE_W-1:0] mem [RAM_DEPTH];
  logic [LINE_W-1:0] rd_lo, rd_hi;
  logic [AW-1:0]     base, base_nx1;
  logic [CW-1:0]     cnt;

  logic [2*LINE_PIX-1:0][PIX_W-1:0] pair;
  logic [WIN-1:0][PIX_W-1:0]        row_pix;
  logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win;

  assign accept    = req_valid & req_ready;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_win   = win;
  assign out_sb    = req_q.sb;
  assign base_nx1  = base + AW'(1);

  // FSM: cnt runs 0..WIN in FETCH; read issued at cnt, captured one cycle later
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = FETCH;
      end
      FETCH: if (cnt == CW'(WIN)) state_nx = OUT;
      OUT: if (out_ready) begin
        req_ready = 1'b1;
        state_nx  = req_valid ? FETCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // RAM is never cleared; writes only land while idle so a fetch sees a stable image
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
    if (state == FETCH) begin
      rd_lo <= mem[base];
      rd_hi <= mem[base_nx1];
    end
  end

  assign pair = {rd_hi, rd_lo};

  for (genvar c = 0; c < WIN; c++) begin : g_col
    ref_win_pix_sel #(.PIX_W(PIX_W), .LINE_PIX(LINE_PIX), .COL(c)) u_sel (
      .pair (pair),
      .pos  (req_q.pos),
      .pix  (row_pix[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      base    <= '0;
      cnt     <= '0;
      win     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && (state != IDLE);
      if (accept) begin
        req_q <= '{addr: req_addr, pos: req_pos, sb: req_sb};
        base  <= req_addr;
        cnt   <= '0;
      end else if (state == FETCH) begin
        base <= base + AW'(ROW_WORDS);
        cnt  <= cnt + CW'(1);
        if (cnt != '0) win[cnt - CW'(1)] <= row_pix;
      end
    end
  end
endmodule

// File: tb/tb_ref_win_fetch.sv
// Directed bench for ref_win_fetch: preloaded ramp image, hand-computed rows,
// latency, stall, write-drop and mid-fetch reset cases.

module tb_ref_win_fetch;
  localparam int WB = 648;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [8:0]   wr_addr;
  logic [127:0] wr_data;
  logic         wr_drop;
  logic         req_valid;
  logic         req_ready;
  logic [8:0]   req_addr;
  logic [3:0]   req_pos;
  logic [191:0] req_sb;
  logic         out_valid;
  logic         out_ready;
  logic [WB-1:0] out_win;
  logic [191:0] out_sb;
  logic         busy;

  logic [7:0] mdl [0:511][0:15];
  int n_chk = 0;
  int n_err = 0;
  int lat;
  int seen;

  ref_win_fetch dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_pos(req_pos), .req_sb(req_sb),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .out_sb(out_sb), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] exp_win(input int addr, input int pos);
    logic [WB-1:0] v;
    v = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        int q, w;
        q = pos + c;
        w = (addr + r*8 + q/16) % 512;
        v[(r*9+c)*8 +: 8] = mdl[w][q%16];
      end
    return v;
  endfunction

  // Present a request, take the accept edge, then count cycles to out_valid.
  task automatic issue(input int addr, input int pos, input logic [191:0] sb);
    req_valid = 1'b1; req_addr = 9'(addr); req_pos = 4'(pos); req_sb = sb;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  localparam logic [191:0] SB1 = {6{32'h1111_0001}};
  localparam logic [191:0] SB2 = {6{32'h2222_0002}};
  localparam logic [191:0] SB3 = {6{32'h3333_0003}};
  localparam logic [191:0] SBA = {6{32'hAAAA_000A}};
  localparam logic [191:0] SBB = {6{32'hBBBB_000B}};
  localparam logic [191:0] SBC = {6{32'hCCCC_000C}};
  localparam logic [191:0] SBD = {6{32'hDDDD_000D}};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; req_pos = '0; req_sb = '0; out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;

    // reset state
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_win", out_win, '0);
    check("rst_out_sb", out_sb, '0);
    check("rst_wr_drop", wr_drop, 1'b0);
    check("rst_busy", busy, 1'b0);

    // preload ramp image: word w, pixel p = (w*16+p) mod 256
    for (int w = 0; w < 512; w++) begin
      wr_en = 1'b1; wr_addr = 9'(w);
      for (int p = 0; p < 16; p++) begin
        mdl[w][p] = 8'((w*16 + p) % 256);
        wr_data[p*8 +: 8] = mdl[w][p];
      end
      tick;
    end
    wr_en = 1'b0;
    tick;
    check("preload_no_drop", wr_drop, 1'b0);

    // 1: aligned window at word 0
    issue(0, 0, SB1);
    check("t1_ready_in_fetch", req_ready, 1'b0);
    check("t1_busy", busy, 1'b1);
    wait_out(lat);
    check("t1_latency", lat, 10);
    check("t1_row0", out_win[71:0], 72'h080706050403020100);
    check("t1_row1", out_win[72 +: 72], 72'h888786858483828180);
    check("t1_row8", out_win[8*72 +: 72], 72'h080706050403020100);
    check("t1_full", out_win, exp_win(0, 0));
    check("t1_sb", out_sb, SB1);
    release_out;
    check("t1_idle_valid", out_valid, 1'b0);
    check("t1_idle_busy", busy, 1'b0);

    // 2: window straddling words 3 and 4
    issue(3, 12, SB2);
    wait_out(lat);
    check("t2_latency", lat, 10);
    check("t2_row0", out_win[71:0], 72'h44434241403F3E3D3C);
    check("t2_full", out_win, exp_win(3, 12));
    check("t2_sb", out_sb, SB2);
    release_out;

    // 3: address wrap at the top of the RAM
    issue(511, 10, SB3);
    wait_out(lat);
    check("t3_latency", lat, 10);
    check("t3_row0", out_win[71:0], 72'h020100FFFEFDFCFBFA);
    check("t3_row1", out_win[72 +: 72], 72'h8281807F7E7D7C7B7A);
    check("t3_full", out_win, exp_win(511, 10));
    release_out;

    // 4: consumer stall, then back-to-back accept
    issue(20, 5, SBA);
    wait_out(lat);
    check("t4_latency_a", lat, 10);
    req_valid = 1'b1; req_addr = 9'd40; req_pos = 4'd0; req_sb = SBB;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_win", out_win, exp_win(20, 5));
      check("t4_hold_sb", out_sb, SBA);
      check("t4_hold_ready", req_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_ready_out", req_ready, 1'b1);
    tick;
    out_ready = 1'b0; req_valid = 1'b0;
    check("t4_b2b_valid", out_valid, 1'b0);
    check("t4_b2b_busy", busy, 1'b1);
    wait_out(lat);
    check("t4_latency_b", lat, 10);
    check("t4_full_b", out_win, exp_win(40, 0));
    check("t4_sb_b", out_sb, SBB);
    release_out;

    // 5: write during FETCH is dropped; write coincident with accept is seen
    issue(0, 0, SB1);
    wr_en = 1'b1; wr_addr = 9'd0;
    for (int p = 0; p < 16; p++) wr_data[p*8 +: 8] = 8'(8'hA0 + p);
    tick;
    wr_en = 1'b0;
    check("t5_drop_pulse", wr_drop, 1'b1);
    tick;
    check("t5_drop_clear", wr_drop, 1'b0);
    wait_out(lat);
    check("t5_row0_orig", out_win[71:0], 72'h080706050403020100);
    check("t5_full_orig", out_win, exp_win(0, 0));
    release_out;
    wr_en = 1'b1; wr_addr = 9'd0;
    for (int p = 0; p < 16; p++) mdl[0][p] = 8'(8'hA0 + p);
    issue(0, 0, SB2);
    wr_en = 1'b0;
    check("t5_idle_no_drop", wr_drop, 1'b0);
    wait_out(lat);
    check("t5_latency", lat, 10);
    check("t5_row0_new", out_win[71:0], 72'hA8A7A6A5A4A3A2A1A0);
    check("t5_full_new", out_win, exp_win(0, 0));
    release_out;

    // 6: reset in the middle of a fetch
    issue(100, 7, SBC);
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_ready", req_ready, 1'b1);
    check("t6_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_win", out_win, '0);
    check("t6_sb", out_sb, '0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid === 1'b1) seen++;
    end
    check("t6_no_partial", seen, 0);
    issue(200, 15, SBD);
    wait_out(lat);
    check("t6_latency", lat, 10);
    check("t6_full", out_win, exp_win(200, 15));
    check("t6_sb_fresh", out_sb, SBD);
    release_out;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
